// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and default latencies.
// Also consumed by the decode controller and hazard/stall logic.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        OpNone  = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMfhi  = 4'd5,
        OpMflo  = 4'd6,
        OpMthi  = 4'd7,
        OpMtlo  = 4'd8
    } mdu_op_e;

    localparam int unsigned MultCyclesDef = 5;
    localparam int unsigned DivCyclesDef  = 10;

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage request/response bundle between the pipeline and the multiply/divide unit.
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic        req;
    mdu_op_e     mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output req, mdu_op, a, b,
        input  start, busy, rd_data, hi, lo
    );

    modport slave (
        input  req, mdu_op, a, b,
        output start, busy, rd_data, hi, lo
    );

endinterface

// File: rtl/mult_div_unit_arith.sv
// Combinational datapath for the multiply/divide unit (the mdu_arith block).
// Produces the full 64-bit HI/LO result in one pass; latency is modelled by the top.
module mult_div_unit_arith
    import mult_div_unit_pkg::*;
(
    input  mdu_op_e     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_res_hi,
    output logic [31:0] o_res_lo,
    output logic        o_div0
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide via magnitudes: truncation toward zero, remainder follows dividend.
    assign w_signed_div = (i_op == OpDiv);
    assign w_a_neg      = w_signed_div & i_a[31];
    assign w_b_neg      = w_signed_div & i_b[31];
    assign w_a_mag      = w_a_neg ? (~i_a + 32'd1) : i_a;
    assign w_b_mag      = w_b_neg ? (~i_b + 32'd1) : i_b;
    assign w_divisor    = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_divisor;
    assign w_r_mag      = w_a_mag % w_divisor;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    assign o_div0 = ((i_op == OpDiv) || (i_op == OpDivu)) && (i_b == 32'd0);

    always_comb begin
        o_res_hi = 32'd0;
        o_res_lo = 32'd0;
        case (i_op)
            OpMult:  {o_res_hi, o_res_lo} = w_prod_s;
            OpMultu: {o_res_hi, o_res_lo} = w_prod_u;
            OpDiv, OpDivu: begin
                o_res_hi = w_rem;
                o_res_lo = w_quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with architectural HI/LO; result is held in tmp registers
// and committed after a fixed busy window so the hazard logic sees a realistic latency.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MultCyclesDef,
    parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
    input  logic              i_clk,
    input  logic              i_reset,
    mult_div_unit_if.slave    bus
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [CntW-1:0] r_cnt;
    logic            r_busy;
    logic [31:0]     r_tmp_hi;
    logic [31:0]     r_tmp_lo;
    logic            r_div0;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;

    logic [31:0]     w_res_hi;
    logic [31:0]     w_res_lo;
    logic            w_div0;
    logic            w_is_md;
    logic            w_is_div;
    logic            w_start;
    logic            w_mt_ok;
    logic            w_done;

    mult_div_unit_arith u_arith (
        .i_op     (bus.mdu_op),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_res_hi (w_res_hi),
        .o_res_lo (w_res_lo),
        .o_div0   (w_div0)
    );

    assign w_is_md  = (bus.mdu_op == OpMult) || (bus.mdu_op == OpMultu) ||
                      (bus.mdu_op == OpDiv)  || (bus.mdu_op == OpDivu);
    assign w_is_div = (bus.mdu_op == OpDiv)  || (bus.mdu_op == OpDivu);
    assign w_start  = w_is_md && !bus.req && !r_busy;
    assign w_mt_ok  = !bus.req && !r_busy;
    assign w_done   = r_busy && (r_cnt == CntW'(1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
            r_div0   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            if (w_start) begin
                r_tmp_hi <= w_res_hi;
                r_tmp_lo <= w_res_lo;
                r_div0   <= w_div0;
                r_cnt    <= w_is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                r_cnt <= r_cnt - CntW'(1);
                if (w_done) begin
                    r_busy <= 1'b0;
                    if (!r_div0) begin
                        r_hi <= r_tmp_hi;
                        r_lo <= r_tmp_lo;
                    end
                end
            end
            // Moves never overlap completion: both require !busy.
            if (w_mt_ok && (bus.mdu_op == OpMthi)) r_hi <= bus.a;
            if (w_mt_ok && (bus.mdu_op == OpMtlo)) r_lo <= bus.a;
        end
    end

    always_comb begin
        bus.rd_data = 32'd0;
        if (bus.mdu_op == OpMfhi) bus.rd_data = r_hi;
        if (bus.mdu_op == OpMflo) bus.rd_data = r_lo;
    end

    assign bus.start = w_start;
    assign bus.busy  = r_busy;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

    a_no_op_while_busy : assert property (
        @(posedge i_clk) disable iff (i_reset) r_busy |-> (bus.mdu_op == OpNone)
    );

endmodule
